// File: rtl/mpu_sequencer_pkg.sv
// Shared constants, opcodes, state encoding and element addressing for the
// 5x5 int8 matrix processing unit sequencer.
package mpu_sequencer_pkg;

    localparam int N     = 5;
    localparam int EW    = 8;
    localparam int MAT_W = N * N * EW;
    localparam int ACC_W = 20;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_OPP   = 3'd2;
    localparam logic [2:0] OP_TRANS = 3'd3;
    localparam logic [2:0] OP_SCALE = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit offset of element (r,c) inside a flat row-major matrix.
    function automatic int elem_off(input int r, input int c);
        return EW * (N * r + c);
    endfunction

    function automatic logic [15:0] sext16(input logic [EW-1:0] v);
        return {{(16-EW){v[EW-1]}}, v};
    endfunction

endpackage

// File: rtl/mpu_dot5.sv
// Combinational signed dot product of one A row and one B column (five int8
// terms), accumulated at 20 bits so no intermediate ever wraps.
module mpu_dot5
    import mpu_sequencer_pkg::*;
(
    input  logic [N*EW-1:0]  row,
    input  logic [N*EW-1:0]  col,
    output logic [ACC_W-1:0] sum
);

    logic [N-1:0][ACC_W-1:0] prod;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_prod
            logic signed [ACC_W-1:0] a_ext;
            logic signed [ACC_W-1:0] b_ext;
            assign a_ext    = {{(ACC_W-EW){row[gi*EW+EW-1]}}, row[gi*EW +: EW]};
            assign b_ext    = {{(ACC_W-EW){col[gi*EW+EW-1]}}, col[gi*EW +: EW]};
            assign prod[gi] = a_ext * b_ext;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + prod[k];
        end
    end

endmodule

// File: rtl/mpu_sequencer.sv
// Command-driven sequencer for the 5x5 int8 MPU: latches operands, runs a
// one-cycle elementwise op or a 25-cycle element-serial multiply, then holds.
module mpu_sequencer
    import mpu_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [EW-1:0]    cmd_scalar,
    input  logic [MAT_W-1:0] cmd_a,
    input  logic [MAT_W-1:0] cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MAT_W-1:0] res_data,
    output logic             res_ovf,
    output logic             res_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [EW-1:0]    scalar_q, scalar_d;
    logic [MAT_W-1:0] a_q, a_d, b_q, b_d;
    logic [MAT_W-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_err_q, res_err_d;
    logic [2:0]       row_q, row_d, col_q, col_d;

    logic [MAT_W-1:0] exec_data;
    logic             exec_ovf, exec_err;
    logic [15:0]      ea, eb, et, esc, wide;

    // Every result is computed at 16 bits; overflow means the value does
    // not survive truncation to 8 bits.
    always_comb begin
        exec_data = '0;
        exec_ovf  = 1'b0;
        exec_err  = 1'b0;
        ea        = '0;
        eb        = '0;
        et        = '0;
        wide      = '0;
        esc       = sext16(scalar_q);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ea = sext16(a_q[elem_off(r, c) +: EW]);
                eb = sext16(b_q[elem_off(r, c) +: EW]);
                et = sext16(a_q[elem_off(c, r) +: EW]);
                case (op_q)
                    OP_ADD:   wide = ea + eb;
                    OP_SUB:   wide = ea - eb;
                    OP_OPP:   wide = 16'd0 - ea;
                    OP_TRANS: wide = et;
                    OP_SCALE: wide = ea * esc;
                    default: begin
                        wide     = '0;
                        exec_err = 1'b1;
                    end
                endcase
                exec_data[elem_off(r, c) +: EW] = wide[EW-1:0];
                if (wide[15:EW-1] != {(17-EW){wide[EW-1]}}) begin
                    exec_ovf = 1'b1;
                end
            end
        end
    end

    logic [N*EW-1:0]  mul_row, mul_col;
    logic [ACC_W-1:0] dot_sum;
    logic             mul_ovf;

    always_comb begin
        mul_row = a_q[elem_off(int'(row_q), 0) +: N*EW];
        mul_col = '0;
        for (int k = 0; k < N; k++) begin
            mul_col[k*EW +: EW] = b_q[elem_off(k, int'(col_q)) +: EW];
        end
    end

    mpu_dot5 u_dot5 (
        .row (mul_row),
        .col (mul_col),
        .sum (dot_sum)
    );

    assign mul_ovf = (dot_sum[ACC_W-1:EW-1] != {(ACC_W-EW+1){dot_sum[EW-1]}});

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        scalar_d   = scalar_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_err_d  = res_err_q;
        row_d      = row_q;
        col_d      = col_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    scalar_d  = cmd_scalar;
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    res_ovf_d = 1'b0;
                    res_err_d = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = (cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = exec_data;
                res_ovf_d  = exec_ovf;
                res_err_d  = exec_err;
                state_d    = ST_DONE;
            end
            ST_MUL: begin
                res_data_d[elem_off(int'(row_q), int'(col_q)) +: EW] = dot_sum[EW-1:0];
                res_ovf_d = res_ovf_q | mul_ovf;
                if (col_q == 3'(N-1)) begin
                    col_d = '0;
                    if (row_q == 3'(N-1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            scalar_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_err_q  <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            scalar_q   <= scalar_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_err_q  <= res_err_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Self-checking bench for mpu_sequencer: vector table through a scoreboard
// queue, plus stall/back-to-back, illegal-op and mid-operation reset sequences.
module tb_mpu_sequencer;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [7:0]   cmd_scalar;
    logic [199:0] cmd_a;
    logic [199:0] cmd_b;
    logic         res_valid;
    logic         res_ready;
    logic [199:0] res_data;
    logic         res_ovf;
    logic         res_err;
    logic         busy;

    mpu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_scalar (cmd_scalar),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [199:0] data;
        logic         ovf;
        logic         err;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [7:0]   sc;
        logic [199:0] a;
        logic [199:0] b;
        exp_t         exp;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk_m(input string name, input logic [199:0] act, input logic [199:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    function automatic int sv(input logic [199:0] m, input int r, input int c);
        logic signed [7:0] t;
        t = m[8*(5*r+c) +: 8];
        return int'(t);
    endfunction

    function automatic logic [199:0] rand_mat();
        logic [199:0] m;
        for (int i = 0; i < 25; i++) m[8*i +: 8] = 8'($urandom);
        return m;
    endfunction

    // Reference results from plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] sc,
                                   input logic [199:0] a, input logic [199:0] b);
        exp_t e;
        int   v;
        logic signed [7:0] s;
        s     = sc;
        e.data = '0;
        e.ovf  = 1'b0;
        e.err  = (op > 3'd5);
        e.lat  = (op == 3'd5) ? 26 : 2;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                case (op)
                    3'd0: v = sv(a, r, c) + sv(b, r, c);
                    3'd1: v = sv(a, r, c) - sv(b, r, c);
                    3'd2: v = -sv(a, r, c);
                    3'd3: v = sv(a, c, r);
                    3'd4: v = int'(s) * sv(a, r, c);
                    3'd5: begin
                        v = 0;
                        for (int k = 0; k < 5; k++) v += sv(a, r, k) * sv(b, k, c);
                    end
                    default: v = 0;
                endcase
                e.data[8*(5*r+c) +: 8] = v[7:0];
                if (v > 127 || v < -128) e.ovf = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic send(input vec_t v);
        chk_b("cmd_ready before accept", cmd_ready, 1'b1);
        cmd_op     = v.op;
        cmd_scalar = v.sc;
        cmd_a      = v.a;
        cmd_b      = v.b;
        cmd_valid  = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid  = 1'b0;
        cmd_a      = rand_mat();
        cmd_b      = rand_mat();
        cmd_scalar = 8'($urandom);
        cmd_op     = 3'($urandom);
        sb_q.push_back(v.exp);
    endtask

    // Called #1 after the accept edge; waits for the result, optionally stalls.
    task automatic collect(input string tag, input int stall);
        int   lat     = 1;
        logic busy_ok = 1'b1;
        logic seen    = 1'b0;
        exp_t e;
        if (!busy || cmd_ready) busy_ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            if (!busy || cmd_ready) busy_ok = 1'b0;
        end
        chk_b({tag, " res_valid"}, seen, 1'b1);
        if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s scoreboard: got empty queue required an entry", tag);
            return;
        end
        e = sb_q.pop_front();
        chk_i({tag, " latency"}, lat, e.lat);
        chk_b({tag, " busy"}, busy_ok, 1'b1);
        chk_m({tag, " data"}, res_data, e.data);
        chk_b({tag, " ovf"}, res_ovf, e.ovf);
        chk_b({tag, " err"}, res_err, e.err);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            chk_m({tag, " stall data"}, res_data, e.data);
            chk_b({tag, " stall cmd_ready"}, cmd_ready, 1'b0);
            chk_b({tag, " stall res_valid"}, res_valid, 1'b1);
        end
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        chk_b({tag, " res_valid after handshake"}, res_valid, 1'b0);
        chk_b({tag, " cmd_ready after handshake"}, cmd_ready, 1'b1);
        chk_m({tag, " data kept"}, res_data, e.data);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, " res_valid"}, res_valid, 1'b0);
        chk_b({tag, " cmd_ready"}, cmd_ready, 1'b1);
        chk_b({tag, " busy"}, busy, 1'b0);
        chk_m({tag, " res_data"}, res_data, '0);
        chk_b({tag, " res_ovf"}, res_ovf, 1'b0);
        chk_b({tag, " res_err"}, res_err, 1'b0);
    endtask

    logic [199:0] all100, opp1, opp2, ident, bidx, rc, trans_exp, scale_exp;
    vec_t         tbl[10];
    vec_t         v;

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        res_ready  = 1'b0;
        cmd_op     = '0;
        cmd_scalar = '0;
        cmd_a      = '0;
        cmd_b      = '0;

        for (int i = 0; i < 25; i++) begin
            all100[8*i +: 8] = 8'd100;
            opp1[8*i +: 8]   = (i == 0) ? 8'h80 : 8'(i);
            opp2[8*i +: 8]   = (i == 0) ? 8'h81 : 8'(i);
            bidx[8*i +: 8]   = 8'(i);
        end
        ident = '0;
        for (int r = 0; r < 5; r++) begin
            ident[8*(6*r) +: 8] = 8'd1;
            for (int c = 0; c < 5; c++) begin
                rc[8*(5*r+c) +: 8]        = 8'(r - c);
                trans_exp[8*(5*r+c) +: 8] = 8'(c - r);
                scale_exp[8*(5*r+c) +: 8] = 8'(-2 * (r - c));
            end
        end

        tbl[0] = '{op: 3'd0, sc: 8'd0, a: all100, b: all100,
                   exp: '{data: {25{8'hC8}}, ovf: 1'b1, err: 1'b0, lat: 2}};
        tbl[1].op = 3'd2; tbl[1].sc = 8'd0; tbl[1].a = opp1; tbl[1].b = rand_mat();
        tbl[1].exp.ovf = 1'b1; tbl[1].exp.err = 1'b0; tbl[1].exp.lat = 2;
        tbl[2].op = 3'd2; tbl[2].sc = 8'd0; tbl[2].a = opp2; tbl[2].b = rand_mat();
        tbl[2].exp.ovf = 1'b0; tbl[2].exp.err = 1'b0; tbl[2].exp.lat = 2;
        for (int i = 0; i < 25; i++) begin
            tbl[1].exp.data[8*i +: 8] = (i == 0) ? 8'h80 : 8'(-i);
            tbl[2].exp.data[8*i +: 8] = (i == 0) ? 8'h7F : 8'(-i);
        end
        tbl[3] = '{op: 3'd5, sc: 8'd0, a: ident, b: bidx,
                   exp: '{data: bidx, ovf: 1'b0, err: 1'b0, lat: 26}};
        tbl[4] = '{op: 3'd1, sc: 8'd0, a: rand_mat(), b: rand_mat(), exp: '{default: 0}};
        tbl[5] = '{op: 3'd4, sc: 8'($urandom), a: rand_mat(), b: rand_mat(), exp: '{default: 0}};
        tbl[6] = '{op: 3'd5, sc: 8'd0, a: rand_mat(), b: rand_mat(), exp: '{default: 0}};
        tbl[7] = '{op: 3'd7, sc: 8'd3, a: rand_mat(), b: rand_mat(),
                   exp: '{data: '0, ovf: 1'b0, err: 1'b1, lat: 2}};
        tbl[8] = '{op: 3'd0, sc: 8'd0, a: rand_mat(), b: rand_mat(), exp: '{default: 0}};
        tbl[9] = '{op: 3'd3, sc: 8'd0, a: rand_mat(), b: rand_mat(), exp: '{default: 0}};
        foreach (tbl[i]) begin
            if (i == 4 || i == 5 || i == 6 || i == 8 || i == 9)
                tbl[i].exp = model(tbl[i].op, tbl[i].sc, tbl[i].a, tbl[i].b);
        end

        #12;
        chk_reset_state("in reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_reset_state("after reset");

        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            collect($sformatf("vec%0d op%0d", i, tbl[i].op), 0);
        end

        // TRANS stalled 10 cycles with SCALE waiting, then SCALE back-to-back.
        v = '{op: 3'd3, sc: 8'd0, a: rc, b: rand_mat(),
              exp: '{data: trans_exp, ovf: 1'b0, err: 1'b0, lat: 2}};
        send(v);
        v = '{op: 3'd4, sc: 8'hFE, a: rc, b: rand_mat(),
              exp: '{data: scale_exp, ovf: 1'b0, err: 1'b0, lat: 2}};
        cmd_op = v.op; cmd_scalar = v.sc; cmd_a = v.a; cmd_b = v.b;
        cmd_valid = 1'b1;
        collect("trans stalled", 10);
        send(v);
        collect("scale b2b", 0);
        chk_i("scale (1,0)", int'(res_data[8*5 +: 8]), 254);
        chk_i("scale (0,1)", int'(res_data[8*1 +: 8]), 2);

        // Reset ten cycles into a multiply; the partial result must vanish.
        v.op = 3'd5; v.sc = 8'd0; v.a = rand_mat(); v.b = rand_mat();
        v.exp = model(v.op, v.sc, v.a, v.b);
        send(v);
        repeat (9) @(posedge clock);
        #1;
        chk_b("mul busy before reset", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("mid-mul reset");
        sb_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        begin
            logic leaked = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clock);
                #1;
                if (res_valid) leaked = 1'b1;
            end
            chk_b("no result after reset", leaked, 1'b0);
        end
        v.op = 3'd0; v.a = rand_mat(); v.b = rand_mat();
        v.exp = model(v.op, v.sc, v.a, v.b);
        send(v);
        collect("add after reset", 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
